// File: rtl/regfile_writer_pkg.sv
// Shared types for the integer register file write-back path: producer
// selection, the x0 constant and bundled in/out views of the writer.
package wires;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {NONE, ALU, LSU, MDU} wb_sel_t;

  typedef struct packed {
    logic               alu_valid;
    logic [4:0]         alu_rd;
    logic [WB_XLEN-1:0] alu_data;
    logic               lsu_valid;
    logic [4:0]         lsu_rd;
    logic [WB_XLEN-1:0] lsu_data;
    logic               mdu_valid;
    logic [4:0]         mdu_rd;
    logic [WB_XLEN-1:0] mdu_data;
    logic               issue_valid;
    logic [4:0]         issue_rd;
    logic [4:0]         raddr1;
    logic [4:0]         raddr2;
  } regfile_writer_in_type;

  typedef struct packed {
    logic               lsu_ready;
    logic               mdu_ready;
    logic               issue_stall;
    logic               busy1;
    logic               busy2;
    logic               fwd1;
    logic               fwd2;
    logic [WB_XLEN-1:0] fwd_data;
    logic               wren;
    logic [4:0]         waddr;
    logic [WB_XLEN-1:0] wdata;
  } regfile_writer_out_type;

endpackage

// File: rtl/regfile_writer_scoreboard.sv
// Pending-destination vector: one bit per architectural register, x0 never
// pending. A set and a clear on the same index in one cycle leaves it set.
module scoreboard
  import wires::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] issue_rd,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output logic       issue_pending,
  output logic       pend1,
  output logic       pend2
);

  logic [31:0] pending_reg;
  logic [31:0] pending_next;

  assign pending_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_bit
      assign pending_next[gi] = (set_en && set_idx == 5'(gi)) ? 1'b1 :
                                (clr_en && clr_idx == 5'(gi)) ? 1'b0 :
                                pending_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign issue_pending = pending_reg[issue_rd];
  assign pend1         = pending_reg[raddr1];
  assign pend2         = pending_reg[raddr2];

endmodule

// File: rtl/regfile_writer.sv
// Write-back arbiter for the single register file write port, with MDU
// anti-starvation, pending-register scoreboard and one-cycle forwarding.
module regfile_writer
  import wires::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic            busy1,
  output logic            busy2,
  output logic            fwd1,
  output logic            fwd2,
  output logic [XLEN-1:0] fwd_data,
  output logic            wren,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);

  localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);

  wb_sel_t         sel;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            mdu_priority;
  logic [3:0]      starve_cnt_reg, starve_cnt_next;
  logic            wren_reg;
  logic [4:0]      waddr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            issue_pending, pend1, pend2;

  assign mdu_priority = mdu_valid && (starve_cnt_reg >= STARVE_THR);

  // Grants are held off during reset so nothing is consumed that will be lost.
  always_comb begin
    sel      = NONE;
    sel_rd   = REG_ZERO;
    sel_data = '0;
    if (rst) begin
      if (alu_valid)                     sel = ALU;
      else if (lsu_valid && !mdu_priority) sel = LSU;
      else if (mdu_valid)                sel = MDU;
    end
    case (sel)
      ALU:     begin sel_rd = alu_rd; sel_data = alu_data; end
      LSU:     begin sel_rd = lsu_rd; sel_data = lsu_data; end
      MDU:     begin sel_rd = mdu_rd; sel_data = mdu_data; end
      default: begin sel_rd = REG_ZERO; sel_data = '0; end
    endcase
  end

  assign lsu_ready = (sel == LSU);
  assign mdu_ready = (sel == MDU);

  always_comb begin
    starve_cnt_next = '0;
    if (mdu_valid && sel != MDU) begin
      starve_cnt_next = (starve_cnt_reg == 4'hF) ? starve_cnt_reg : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wren_reg       <= 1'b0;
      waddr_reg      <= REG_ZERO;
      wdata_reg      <= '0;
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      wren_reg       <= (sel != NONE) && (sel_rd != REG_ZERO);
      if (sel != NONE) begin
        waddr_reg <= sel_rd;
        wdata_reg <= sel_data;
      end
    end
  end

  scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .set_en        (issue_valid && !issue_pending),
    .set_idx       (issue_rd),
    .clr_en        (wren_reg),
    .clr_idx       (waddr_reg),
    .issue_rd      (issue_rd),
    .raddr1        (raddr1),
    .raddr2        (raddr2),
    .issue_pending (issue_pending),
    .pend1         (pend1),
    .pend2         (pend2)
  );

  assign issue_stall = issue_pending;
  assign fwd1        = wren_reg && (waddr_reg == raddr1) && (raddr1 != REG_ZERO);
  assign fwd2        = wren_reg && (waddr_reg == raddr2) && (raddr2 != REG_ZERO);
  assign busy1       = pend1 && !fwd1;
  assign busy2       = pend2 && !fwd2;
  assign fwd_data    = wdata_reg;

  assign wren  = wren_reg;
  assign waddr = waddr_reg;
  assign wdata = wdata_reg;

endmodule
